// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution layer.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_EMIT,
    S_DONE
  } conv_state_e;

  // Counter width helper; never returns zero so single-entry ranges still get a bit.
  function automatic int clog2w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Arithmetic shift right by frac with round-half-up, then clamp to a dw-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned frac,
                                                   input int unsigned dw);
    logic signed [63:0] half;
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    half = (frac == 0) ? 64'sd0 : (64'sd1 <<< (frac - 1));
    sh   = (acc + half) >>> frac;
    hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (dw - 1));
    if (sh > hi) return hi;
    else if (sh < lo) return lo;
    else return sh;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One filter lane: signed multiply-accumulate with rounded, saturated result.
// CONV_RELU_EN clamps negative results to zero.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int ACC_W      = 37
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] pix,
  input  logic signed [DATA_WIDTH-1:0] wgt,
  input  logic                         active,
  output logic        [DATA_WIDTH-1:0] result
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        acc_q;
  logic        [DATA_WIDTH-1:0]   sat;
  logic        [DATA_WIDTH-1:0]   shaped;

  assign prod = pix * wgt;

  always_ff @(posedge clk) begin
    if (reset || clear) acc_q <= '0;
    else if (en)        acc_q <= acc_q + ACC_W'(prod);
  end

  assign sat = DATA_WIDTH'(round_sat(64'(acc_q), FRAC, DATA_WIDTH));

`ifdef CONV_RELU_EN
  assign shaped = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign shaped = sat;
`endif

  assign result = active ? shaped : '0;

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming conv layer: N_PAR filter lanes, implicit zero padding, one output beat per pixel/group.
// Optional build macro CONV_RELU_EN (ReLU on lane outputs, see conv_mac_lane).
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | clear accumulators and tap counters
// MAC    | one (d,r,c) tap per cycle, D*F*F cycles
// EMIT   | hold beat until out_ready, then advance col/row/group
// DONE   | one-cycle done pulse, back to IDLE
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int FRAC       = 8,
  parameter  int D          = 1,
  parameter  int H          = 32,
  parameter  int W          = 32,
  parameter  int F          = 5,
  parameter  int K          = 6,
  parameter  int N_PAR      = 2,
  parameter  int P          = F / 2,
  parameter  int S          = 1,
  localparam int HO         = (H + 2 * P - F) / S + 1,
  localparam int WO         = (W + 2 * P - F) / S + 1,
  localparam int NG         = (K + N_PAR - 1) / N_PAR,
  localparam int GW         = clog2w(NG),
  localparam int RW         = clog2w(HO),
  localparam int CW         = clog2w(WO)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [D*H*W*DATA_WIDTH-1:0]       image,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]     filters,
  output logic                              busy,
  output logic                              done,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_PAR*DATA_WIDTH-1:0]       out_data,
  output logic [N_PAR-1:0]                  out_lane_valid,
  output logic [GW-1:0]                     out_group,
  output logic [RW-1:0]                     out_row,
  output logic [CW-1:0]                     out_col
);

  localparam int TAPS  = D * F * F;
  localparam int ACC_W = 2 * DATA_WIDTH + clog2w(TAPS);
  localparam int NPIX  = D * H * W;
  localparam int NWGT  = K * D * F * F;
  localparam int PIW   = clog2w(NPIX);
  localparam int WIW   = clog2w(NWGT);
  localparam int TDW   = clog2w(D);
  localparam int TFW   = clog2w(F);

  conv_state_e state_q, state_d;

  logic [GW-1:0]  grp_q;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  logic [TDW-1:0] tap_d_q;
  logic [TFW-1:0] tap_r_q;
  logic [TFW-1:0] tap_c_q;
  logic           tap_last;
  logic           beat_last;

  logic signed [DATA_WIDTH-1:0] img_a [NPIX];
  logic signed [DATA_WIDTH-1:0] wgt_a [NWGT];
  logic signed [DATA_WIDTH-1:0] pix;
  int                           src_r;
  int                           src_c;
  logic [PIW-1:0]               pidx;
  logic [N_PAR-1:0]             lane_ok;
  logic [N_PAR-1:0]             lane_en;

  // Element 0 of each flat bus sits in the most significant slot.
  for (genvar i = 0; i < NPIX; i++) begin : g_img
    assign img_a[i] = image[(NPIX-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end
  for (genvar i = 0; i < NWGT; i++) begin : g_wgt
    assign wgt_a[i] = filters[(NWGT-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign tap_last  = (tap_d_q == TDW'(D - 1)) && (tap_r_q == TFW'(F - 1)) &&
                     (tap_c_q == TFW'(F - 1));
  assign beat_last = (grp_q == GW'(NG - 1)) && (row_q == RW'(HO - 1)) &&
                     (col_q == CW'(WO - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (tap_last) state_d = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = beat_last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tap_d_q <= '0;
      tap_r_q <= '0;
      tap_c_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          grp_q <= '0;
          row_q <= '0;
          col_q <= '0;
        end
        S_LOAD: begin
          tap_d_q <= '0;
          tap_r_q <= '0;
          tap_c_q <= '0;
        end
        S_MAC: begin
          if (tap_c_q == TFW'(F - 1)) begin
            tap_c_q <= '0;
            if (tap_r_q == TFW'(F - 1)) begin
              tap_r_q <= '0;
              tap_d_q <= (tap_d_q == TDW'(D - 1)) ? '0 : tap_d_q + TDW'(1);
            end else begin
              tap_r_q <= tap_r_q + TFW'(1);
            end
          end else begin
            tap_c_q <= tap_c_q + TFW'(1);
          end
        end
        S_EMIT: if (out_ready) begin
          if (col_q == CW'(WO - 1)) begin
            col_q <= '0;
            if (row_q == RW'(HO - 1)) begin
              row_q <= '0;
              grp_q <= (grp_q == GW'(NG - 1)) ? '0 : grp_q + GW'(1);
            end else begin
              row_q <= row_q + RW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Padding is implicit: out-of-image taps feed a zero pixel instead of reading a padded copy.
  always_comb begin
    src_r = int'(row_q) * S + int'(tap_r_q) - P;
    src_c = int'(col_q) * S + int'(tap_c_q) - P;
    pidx  = PIW'((int'(tap_d_q) * H + src_r) * W + src_c);
    pix   = '0;
    if (src_r >= 0 && src_r < H && src_c >= 0 && src_c < W) pix = img_a[pidx];
  end

  for (genvar j = 0; j < N_PAR; j++) begin : g_lane
    int                           k_j;
    logic [WIW-1:0]               widx_j;
    logic signed [DATA_WIDTH-1:0] wgt_j;

    assign k_j        = int'(grp_q) * N_PAR + j;
    assign widx_j     = WIW'(((k_j * D + int'(tap_d_q)) * F + int'(tap_r_q)) * F + int'(tap_c_q));
    assign lane_ok[j] = (k_j < K);
    assign wgt_j      = lane_ok[j] ? wgt_a[widx_j] : '0;
    assign lane_en[j] = (state_q == S_EMIT) && lane_ok[j];

    conv_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC       (FRAC),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == S_LOAD),
      .en     (state_q == S_MAC),
      .pix    (pix),
      .wgt    (wgt_j),
      .active (lane_en[j]),
      .result (out_data[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign out_lane_valid = lane_en;
  assign out_group      = grp_q;
  assign out_row        = row_q;
  assign out_col        = col_q;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench for conv_layer_stream: 4x4 image, 3x3 filters, pad 1, K=3 over 2 lanes.
module tb_conv_layer_stream;

  localparam int NB     = 32;
  localparam int TAPS   = 9;
  localparam int BUDGET = 2000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         out_ready;
  logic [255:0] image;
  logic [431:0] filters;
  logic         busy, done, out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_lane_valid;
  logic [0:0]   out_group;
  logic [1:0]   out_row;
  logic [1:0]   out_col;

  conv_layer_stream #(
    .DATA_WIDTH(16), .FRAC(8), .D(1), .H(4), .W(4), .F(3),
    .K(3), .N_PAR(2), .P(1), .S(1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .image          (image),
    .filters        (filters),
    .busy           (busy),
    .done           (done),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .out_group      (out_group),
    .out_row        (out_row),
    .out_col        (out_col)
  );

  always #5 clk = ~clk;

  // e4/e6/e9: expected result per filter for beats whose window covers 4, 6 or 9 real pixels
  typedef struct packed {
    logic [15:0]      pix;
    logic [2:0][15:0] w;
    logic [2:0][15:0] e4;
    logic [2:0][15:0] e6;
    logic [2:0][15:0] e9;
  } vec_t;

  vec_t tbl [3];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_lane(input int rid, input int b, input int j);
    int g, k, r, c, n;
    logic [15:0] v;
    g = b / 16;
    k = g * 2 + j;
    if (k >= 3) return 16'h0000;
    r = (b % 16) / 4;
    c = b % 4;
    n = ((r == 0 || r == 3) ? 2 : 3) * ((c == 0 || c == 3) ? 2 : 3);
    if (n == 4)      v = tbl[rid].e4[k];
    else if (n == 6) v = tbl[rid].e6[k];
    else             v = tbl[rid].e9[k];
    return relu(v);
  endfunction

  task automatic set_inputs(input int rid);
    image = {16{tbl[rid].pix}};
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 9; t++)
        filters[(26 - (k * 9 + t)) * 16 +: 16] = tbl[rid].w[k];
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_lanes"}, out_lane_valid, 0);
    chk({tag, "_idx"}, {out_group, out_row, out_col}, 0);
  endtask

  task automatic check_beat(input int rid, input int b);
    logic [4:0] ei;
    int g;
    g  = b / 16;
    ei = {1'(g), 2'((b % 16) / 4), 2'(b % 4)};
    chk($sformatf("v%0d_b%0d_lane0", rid, b), out_data[15:0], exp_lane(rid, b, 0));
    chk($sformatf("v%0d_b%0d_lane1", rid, b), out_data[31:16], exp_lane(rid, b, 1));
    chk($sformatf("v%0d_b%0d_mask", rid, b), out_lane_valid, (g == 0) ? 2'b11 : 2'b01);
    chk($sformatf("v%0d_b%0d_idx", rid, b), {out_group, out_row, out_col}, ei);
  endtask

  task automatic run_pass(input int rid, input int stall_at, input int abort_at, input bit poke);
    int beat, cyc, lat, stall_cnt, since_hs, bad;
    bit aborted, lat_done;
    logic [31:0] cap_d;
    logic [4:0]  cap_i;
    set_inputs(rid);
    beat = 0; cyc = 0; lat = 0; stall_cnt = 0; since_hs = 0; bad = 0;
    aborted = 0; lat_done = 0;
    cap_d = '0; cap_i = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (beat < NB && cyc < BUDGET && !aborted) begin
      out_ready = 1'b1;
      start     = 1'b0;
      if (out_valid) begin
        if (!lat_done) begin
          chk("latency", lat + 1, TAPS + 2);
          lat_done = 1;
        end
        if (beat == stall_at && stall_cnt < 10) begin
          out_ready = 1'b0;
          if (stall_cnt == 0) begin
            cap_d = out_data;
            cap_i = {out_group, out_row, out_col};
          end else if (out_data !== cap_d || {out_group, out_row, out_col} !== cap_i) begin
            bad++;
          end
          stall_cnt++;
        end else begin
          if (beat == stall_at) chk("stall_stable", bad, 0);
          check_beat(rid, beat);
          beat++;
          since_hs = 0;
        end
      end else begin
        if (beat == 0) lat++;
        since_hs++;
        if (poke && beat == 3 && since_hs == 2) start = 1'b1;
        if (beat == abort_at && since_hs == 4) begin
          chk("abort_in_mac", busy, 1);
          reset = 1'b1;
          step();
          chk_reset_vals("abort");
          reset = 1'b0;
          aborted = 1;
        end
      end
      if (!aborted) begin
        step();
        cyc++;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (aborted) return;
    chk("beats", beat, NB);
    chk("pass_cycles", cyc, NB * (TAPS + 2) + ((stall_at >= 0) ? 10 : 0));
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    step();
    chk("done_low", done, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    // all pixels and weights 1.0 / 2.0 / -1.0
    tbl[0].pix = 16'h0100;
    tbl[0].w[0] = 16'h0100; tbl[0].w[1] = 16'h0200; tbl[0].w[2] = 16'hFF00;
    tbl[0].e4[0] = 16'h0400; tbl[0].e4[1] = 16'h0800; tbl[0].e4[2] = 16'hFC00;
    tbl[0].e6[0] = 16'h0600; tbl[0].e6[1] = 16'h0C00; tbl[0].e6[2] = 16'hFA00;
    tbl[0].e9[0] = 16'h0900; tbl[0].e9[1] = 16'h1200; tbl[0].e9[2] = 16'hF700;
    // 127.0 everywhere, filter 1 negative: saturation both ways
    tbl[1].pix = 16'h7F00;
    tbl[1].w[0] = 16'h7F00; tbl[1].w[1] = 16'h8100; tbl[1].w[2] = 16'h7F00;
    tbl[1].e4[0] = 16'h7FFF; tbl[1].e4[1] = 16'h8000; tbl[1].e4[2] = 16'h7FFF;
    tbl[1].e6[0] = 16'h7FFF; tbl[1].e6[1] = 16'h8000; tbl[1].e6[2] = 16'h7FFF;
    tbl[1].e9[0] = 16'h7FFF; tbl[1].e9[1] = 16'h8000; tbl[1].e9[2] = 16'h7FFF;
    // 1 LSB pixels with 0.5 / 1.5 / -0.5 weights: round-half-up on the 9-tap beats
    tbl[2].pix = 16'h0001;
    tbl[2].w[0] = 16'h0080; tbl[2].w[1] = 16'h0180; tbl[2].w[2] = 16'hFF80;
    tbl[2].e4[0] = 16'h0002; tbl[2].e4[1] = 16'h0006; tbl[2].e4[2] = 16'hFFFE;
    tbl[2].e6[0] = 16'h0003; tbl[2].e6[1] = 16'h0009; tbl[2].e6[2] = 16'hFFFD;
    tbl[2].e9[0] = 16'h0005; tbl[2].e9[1] = 16'h000E; tbl[2].e9[2] = 16'hFFFC;

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    set_inputs(0);
    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();

    for (int v = 0; v < 3; v++) run_pass(v, -1, -1, 1'(v == 2));
    run_pass(0, 6, -1, 1'b0);
    run_pass(0, -1, 5, 1'b0);
    run_pass(0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_layer_stream.md
CONV_LAYER_STREAM -- requirements
Module: conv_layer_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed two's-complement sample/weight width.
REQ-002 Parameter FRAC, default 8: fractional bits of the fixed-point format.
REQ-003 Parameter D, default 1: image and filter depth (channels).
REQ-004 Parameter H and W, default 32 and 32: image height and width.
REQ-005 Parameter F, default 5: filter size (F x F).
REQ-006 Parameter K, default 6: number of filters.
REQ-007 Parameter N_PAR, default 2: parallel MAC lanes (filters computed concurrently).
REQ-008 Parameter P, default F/2: zero-padding pixels on each border.
REQ-009 Parameter S, default 1: stride; derived HO=(H+2P-F)/S+1, WO=(W+2P-F)/S+1, NG=ceil(K/N_PAR).
REQ-010 clk  in  1  single clock; all state updates on rising edge.
REQ-011 reset  in  1  synchronous, active-high reset.
REQ-012 start  in  1  one-cycle request to begin a layer pass; sampled only in IDLE.
REQ-013 image  in  D*H*W*DATA_WIDTH  flat image, order [d][row][col], MSB-first; held stable while busy.
REQ-014 filters  in  K*D*F*F*DATA_WIDTH  flat weights, order [k][d][r][c]; held stable while busy.
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle pulse after the last output beat is accepted.
REQ-017 out_valid  out  1  output beat available.
REQ-018 out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
REQ-019 out_data  out  N_PAR*DATA_WIDTH  lane j = filter g*N_PAR+j result for the current pixel.
REQ-020 out_lane_valid  out  N_PAR  lane mask; lane j set iff g*N_PAR+j < K.
REQ-021 out_group, out_row, out_col  out  clog2 widths  indices of the current beat.

Function
REQ-022 FSM states IDLE, LOAD, MAC, EMIT, DONE; reset enters IDLE.
REQ-023 IDLE->LOAD on start; start in any other state is ignored.
REQ-024 LOAD: clear all lane accumulators and the tap counter (1 cycle), then go to MAC.
REQ-025 MAC: one tap (d,r,c) per cycle across all lanes, D*F*F cycles, then go to EMIT.
REQ-026 Taps with source coordinates outside [0,H-1] x [0,W-1] SHALL contribute zero (implicit padding; no padded copy).
REQ-027 Product is a full 2*DATA_WIDTH signed product; accumulator width is 2*DATA_WIDTH+clog2(D*F*F) with no overflow.
REQ-028 Result = accumulator arithmetically shifted right by FRAC, round-half-up, saturated to DATA_WIDTH signed range.
REQ-029 EMIT: out_valid high with stable data and indices until handshake; out_ready low stalls indefinitely.
REQ-030 On handshake, advance col, then row, then group (raster order within a group, groups in order), then go to LOAD; after the last beat go to DONE.
REQ-031 DONE: pulse done for 1 cycle, deassert busy, go to IDLE.
REQ-032 Lanes masked off by out_lane_valid SHALL output zero.
REQ-033 Latency per beat: D*F*F+2 cycles from LOAD to first out_valid; the pass totals NG*HO*WO beats.

Reset
REQ-034 Reset SHALL dominate every state, including mid-MAC and mid-EMIT: the next state is IDLE.
REQ-035 Reset values: busy=0, done=0, out_valid=0, out_data=0, out_lane_valid=0, indices=0, accumulators=0.

Configuration
REQ-036 With CONV_RELU_EN defined, negative saturated results SHALL be replaced by zero before output.
REQ-037 Without CONV_RELU_EN, signed saturated results SHALL pass unmodified.

Structure
REQ-038 A shared package conv_pkg holds the FSM state enum, the clog2 helper, and the saturate/round function.
REQ-039 Sub-module conv_mac_lane (one accumulator, clear/enable, round/saturate output) instantiated N_PAR times.

Verification
REQ-040 D=1, H=W=4, F=3, P=1, K=1, N_PAR=1, all pixels 1.0, all weights 1.0 -> corner beats 4.0, edge beats 6.0, interior beats 9.0; 16 beats, then done.
REQ-041 K=3, N_PAR=2 -> NG=2; second group out_lane_valid=2'b01 and lane 1 = 0.
REQ-042 Weights 127.0 on an all-127.0 image (DATA_WIDTH=16, FRAC=8) -> every lane saturates to 0x7FFF; with negative weights -> 0x8000, or 0 with CONV_RELU_EN.
REQ-043 out_ready held low 10 cycles in EMIT -> out_valid and out_data stable and no index advance; beat is consumed on the first ready cycle.
REQ-044 Reset asserted during MAC of beat 5 -> IDLE next cycle with all outputs at reset values; a new start reproduces the full pass from beat 0.
REQ-045 Start pulsed while busy -> ignored; beat count and done timing unchanged.
